// File: rtl/l2_cache_if.sv
// L1-side request/response and memory-side block bus for the L2 cache.
// Blocks are packed arrays of words; word i sits at index [i].
interface l2_cache_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int BLOCK_SIZE = 32
);
    typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;

    logic [ADDR_WIDTH-1:0] l1_cache_addr;
    block_t                l1_cache_data_in;
    block_t                l1_block_data_out;
    logic                  l1_block_valid;
    logic                  l1_cache_read;
    logic                  l1_cache_write;
    logic                  l1_cache_ready;
    logic                  l1_cache_hit;
    block_t                mem_data_block;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    block_t                mem_data_out;
    logic                  mem_read;
    logic                  mem_write;

    modport slave (
        input  l1_cache_addr, l1_cache_data_in,
        input  l1_cache_read, l1_cache_write,
        input  mem_data_block, mem_ready,
        output l1_block_data_out, l1_block_valid,
        output l1_cache_ready, l1_cache_hit,
        output mem_addr, mem_data_out,
        output mem_read, mem_write
    );

    modport master (
        output l1_cache_addr, l1_cache_data_in,
        output l1_cache_read, l1_cache_write,
        output mem_data_block, mem_ready,
        input  l1_block_data_out, l1_block_valid,
        input  l1_cache_ready, l1_cache_hit,
        input  mem_addr, mem_data_out,
        input  mem_read, mem_write
    );
endinterface

// File: rtl/l2_cache.sv
// 4-way set-associative write-through/write-allocate L2 cache with
// true-LRU replacement; whole-block transfers on both sides.
module l2_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int CACHE_SIZE = 512,
    parameter int BLOCK_SIZE = 32,
    parameter int NUM_WAYS   = 4
) (
    input logic       clk,
    input logic       rst_n,
    l2_cache_if.slave bus
);
    localparam int SETS  = CACHE_SIZE / NUM_WAYS;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W;
    localparam int WAY_W = $clog2(NUM_WAYS);

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] MISS_WAIT = 1'b1;

    typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;

    logic [NUM_WAYS-1:0] valid_q [SETS];
    logic [TAG_W-1:0]    tag_q   [SETS][NUM_WAYS];
    block_t              data_q  [SETS][NUM_WAYS];
    logic [WAY_W-1:0]    rank_q  [SETS][NUM_WAYS];

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] look_addr;
    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic [WAY_W-1:0]      victim;
    logic                  found_inv;
    logic                  accept_wr;
    logic                  accept_rd;
    logic                  fill;
    logic                  upd;
    logic [WAY_W-1:0]      upd_way;
    block_t                wr_data;

    // While waiting on a fill, the lookup follows the pending miss address.
    assign look_addr = (state == MISS_WAIT) ? bus.mem_addr : bus.l1_cache_addr;
    assign idx       = look_addr[IDX_W-1:0];
    assign tag       = look_addr[ADDR_WIDTH-1:IDX_W];

    assign bus.l1_cache_ready = (state == IDLE);

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        victim    = '0;
        found_inv = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!found_inv && !valid_q[idx][w]) begin
                found_inv = 1'b1;
                victim    = WAY_W'(w);
            end
        end
        if (!found_inv) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (rank_q[idx][w] == WAY_W'(NUM_WAYS - 1))
                    victim = WAY_W'(w);
            end
        end
    end

    assign accept_wr = (state == IDLE) && bus.l1_cache_write;
    assign accept_rd = (state == IDLE) && bus.l1_cache_read
                       && !bus.l1_cache_write;
    assign fill      = (state == MISS_WAIT) && bus.mem_ready;
    assign upd       = accept_wr || (accept_rd && hit) || fill;
    assign upd_way   = hit ? hit_way : victim;
    assign wr_data   = fill ? bus.mem_data_block : bus.l1_cache_data_in;

    always_ff @(posedge clk) begin
        if (accept_wr || fill) begin
            data_q[idx][upd_way] <= wr_data;
            tag_q[idx][upd_way]  <= tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++)
                    rank_q[s][w] <= WAY_W'(w);
            end
            state                 <= IDLE;
            bus.l1_block_valid    <= 1'b0;
            bus.l1_cache_hit      <= 1'b0;
            bus.l1_block_data_out <= '0;
            bus.mem_read          <= 1'b0;
            bus.mem_write         <= 1'b0;
            bus.mem_addr          <= '0;
            bus.mem_data_out      <= '0;
        end else begin
            bus.mem_write <= 1'b0;
            if (upd) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_W'(w) == upd_way)
                        rank_q[idx][w] <= '0;
                    else if (rank_q[idx][w] < rank_q[idx][upd_way])
                        rank_q[idx][w] <= rank_q[idx][w] + 1'b1;
                end
            end
            if (accept_wr || fill)
                valid_q[idx][upd_way] <= 1'b1;
            if (accept_wr) begin
                bus.l1_cache_hit   <= hit;
                bus.l1_block_valid <= 1'b0;
                bus.mem_addr       <= bus.l1_cache_addr;
                bus.mem_data_out   <= bus.l1_cache_data_in;
                bus.mem_write      <= 1'b1;
            end else if (accept_rd) begin
                bus.l1_cache_hit <= hit;
                if (hit) begin
                    bus.l1_block_data_out <= data_q[idx][hit_way];
                    bus.l1_block_valid    <= 1'b1;
                end else begin
                    bus.l1_block_valid <= 1'b0;
                    bus.mem_addr       <= bus.l1_cache_addr;
                    bus.mem_read       <= 1'b1;
                    state              <= MISS_WAIT;
                end
            end else if (fill) begin
                bus.l1_block_data_out <= bus.mem_data_block;
                bus.l1_block_valid    <= 1'b1;
                bus.mem_read          <= 1'b0;
                state                 <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_l2_cache.sv
// Scoreboard bench for l2_cache: expected responses are queued at request
// time and popped when the cache answers; memory is a small block model.
module tb_l2_cache;
    typedef logic [31:0][31:0] block_t;
    typedef struct {
        logic   hit;
        block_t data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb [$];
    block_t mem_m [int];

    always #5 clk = ~clk;

    l2_cache_if bus ();
    l2_cache dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    function automatic block_t pattern(logic [31:0] base);
        block_t b;
        for (int i = 0; i < 32; i++) b[i] = base ^ 32'(i);
        return b;
    endfunction

    function automatic block_t mem_get(logic [10:0] a);
        if (mem_m.exists(int'(a))) return mem_m[int'(a)];
        return pattern({5'h0, a, 16'h1234});
    endfunction

    task automatic chk(string tag, block_t got, block_t exp);
        int k;
        checks++;
        if (got !== exp) begin
            errors++;
            k = 0;
            for (int i = 31; i >= 0; i--) if (got[i] !== exp[i]) k = i;
            $display("FAIL %s: got word%0d=%h expected %h",
                     tag, k, got[k], exp[k]);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
    endtask

    task automatic do_read(logic [10:0] a, logic exp_hit);
        exp_t e;
        e.hit  = exp_hit;
        e.data = mem_get(a);
        sb.push_back(e);
        @(negedge clk);
        bus.l1_cache_addr = a;
        bus.l1_cache_read = 1'b1;
        @(posedge clk) #1;
        bus.l1_cache_read = 1'b0;
        if (bus.mem_read) begin
            chk("miss_addr", block_t'(bus.mem_addr), block_t'(a));
            chk("miss_busy", block_t'(bus.l1_cache_ready), '0);
            repeat (2) @(posedge clk);
            #1 chk("miss_hold", block_t'(bus.mem_read), block_t'(1));
            @(negedge clk);
            bus.mem_data_block = mem_get(bus.mem_addr);
            bus.mem_ready      = 1'b1;
            @(posedge clk) #1;
            bus.mem_ready = 1'b0;
        end
        e = sb.pop_front();
        chk("rd_hit", block_t'(bus.l1_cache_hit), block_t'(e.hit));
        chk("rd_valid", block_t'(bus.l1_block_valid), block_t'(1));
        chk("rd_data", bus.l1_block_data_out, e.data);
        chk("rd_ready", block_t'(bus.l1_cache_ready), block_t'(1));
        chk("rd_memrd", block_t'(bus.mem_read), '0);
    endtask

    task automatic do_write(logic [10:0] a, logic [31:0] base,
                            logic exp_hit, logic also_rd);
        exp_t e;
        e.hit  = exp_hit;
        e.data = pattern(base);
        sb.push_back(e);
        @(negedge clk);
        bus.l1_cache_addr    = a;
        bus.l1_cache_data_in = e.data;
        bus.l1_cache_write   = 1'b1;
        bus.l1_cache_read    = also_rd;
        @(posedge clk) #1;
        bus.l1_cache_write = 1'b0;
        bus.l1_cache_read  = 1'b0;
        e = sb.pop_front();
        mem_m[int'(a)] = e.data;
        chk("wr_strobe", block_t'(bus.mem_write), block_t'(1));
        chk("wr_addr", block_t'(bus.mem_addr), block_t'(a));
        chk("wr_data", bus.mem_data_out, e.data);
        chk("wr_hit", block_t'(bus.l1_cache_hit), block_t'(e.hit));
        chk("wr_valid", block_t'(bus.l1_block_valid), '0);
        chk("wr_ready", block_t'(bus.l1_cache_ready), block_t'(1));
        chk("wr_nomemrd", block_t'(bus.mem_read), '0);
        @(posedge clk) #1;
        chk("wr_pulse", block_t'(bus.mem_write), '0);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        bus.l1_cache_addr    = '0;
        bus.l1_cache_data_in = '0;
        bus.l1_cache_read    = 1'b0;
        bus.l1_cache_write   = 1'b0;
        bus.mem_data_block   = '0;
        bus.mem_ready        = 1'b0;
        mem_m[10] = pattern(32'hDEADBEEF);
        do_reset();

        chk("rst_ready", block_t'(bus.l1_cache_ready), block_t'(1));
        chk("rst_valid", block_t'(bus.l1_block_valid), '0);
        chk("rst_hit", block_t'(bus.l1_cache_hit), '0);
        chk("rst_memrd", block_t'(bus.mem_read), '0);
        chk("rst_memwr", block_t'(bus.mem_write), '0);
        chk("rst_maddr", block_t'(bus.mem_addr), '0);
        chk("rst_mdata", bus.mem_data_out, '0);
        chk("rst_l1data", bus.l1_block_data_out, '0);

        do_read(11'h00A, 1'b0);
        do_read(11'h00A, 1'b1);
        chk("word0", block_t'(bus.l1_block_data_out[0]), block_t'(32'hDEADBEEF));
        chk("word31", block_t'(bus.l1_block_data_out[31]),
            block_t'(32'hDEADBEEF ^ 32'd31));

        do_write(11'h014, 32'hA5A5A5A5, 1'b0, 1'b0);
        do_write(11'h014, 32'h5A5A5A5A, 1'b1, 1'b0);
        do_read(11'h014, 1'b1);
        chk("wr_word0", block_t'(bus.l1_block_data_out[0]), block_t'(32'h5A5A5A5A));

        // write wins when both strobes are high
        do_write(11'h055, 32'h01234567, 1'b0, 1'b1);

        // back-to-back writes
        @(negedge clk);
        bus.l1_cache_addr    = 11'h030;
        bus.l1_cache_data_in = pattern(32'h11110000);
        bus.l1_cache_write   = 1'b1;
        @(posedge clk) #1;
        chk("b2b_addr0", block_t'(bus.mem_addr), block_t'(11'h030));
        @(negedge clk);
        bus.l1_cache_addr    = 11'h031;
        bus.l1_cache_data_in = pattern(32'h22220000);
        @(posedge clk) #1;
        bus.l1_cache_write = 1'b0;
        chk("b2b_strobe", block_t'(bus.mem_write), block_t'(1));
        chk("b2b_addr1", block_t'(bus.mem_addr), block_t'(11'h031));
        chk("b2b_data1", bus.mem_data_out, pattern(32'h22220000));
        mem_m[48] = pattern(32'h11110000);
        mem_m[49] = pattern(32'h22220000);
        do_read(11'h030, 1'b1);
        do_read(11'h031, 1'b1);

        // set 10: fifth tag evicts the LRU way
        do_read(11'h08A, 1'b0);
        do_read(11'h10A, 1'b0);
        do_read(11'h18A, 1'b0);
        do_read(11'h20A, 1'b0);
        do_read(11'h00A, 1'b0);
        do_read(11'h10A, 1'b1);
        do_read(11'h08A, 1'b0);

        do_reset();
        do_read(11'h00A, 1'b0);
        do_read(11'h08A, 1'b0);
        do_read(11'h10A, 1'b0);
        do_read(11'h18A, 1'b0);
        do_read(11'h00A, 1'b1);
        do_read(11'h20A, 1'b0);
        do_read(11'h00A, 1'b1);
        do_read(11'h08A, 1'b0);

        // reset while a fetch is outstanding
        do_reset();
        @(negedge clk);
        bus.l1_cache_addr = 11'h00A;
        bus.l1_cache_read = 1'b1;
        @(posedge clk) #1;
        bus.l1_cache_read = 1'b0;
        chk("abort_pre", block_t'(bus.mem_read), block_t'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("abort_memrd", block_t'(bus.mem_read), '0);
        chk("abort_ready", block_t'(bus.l1_cache_ready), block_t'(1));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        do_read(11'h00A, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/l2_cache.md
Name: l2_cache

Overview:
Unified, 4-way set-associative L2 cache between the L1 cache and main memory. It transfers whole blocks on both sides. Policy is write-through with write-allocate and true-LRU replacement per set. Read misses fetch the block from memory. All writes install the full block and are posted to memory as a one-cycle write.

Parameters:
DATA_WIDTH, 32, bits per word
ADDR_WIDTH, 11, block address width (no byte/word offset; every transfer is a whole block)
CACHE_SIZE, 512, total number of blocks; sets = CACHE_SIZE/NUM_WAYS (128), index bits = log2(sets) (7)
BLOCK_SIZE, 32, words per block; block bus width = BLOCK_SIZE*DATA_WIDTH (1024)
NUM_WAYS, 4, associativity (power of 2)

Ports:
clk  in  1  single clock; all state changes on the rising edge
rst_n  in  1  asynchronous, active-low reset
l1_cache_addr  in  ADDR_WIDTH  block address; index = low log2(sets) bits, tag = remaining upper bits
l1_cache_data_in  in  BLOCK_SIZE x DATA_WIDTH packed  write block; word i = [i]
l1_block_data_out  out  BLOCK_SIZE x DATA_WIDTH packed  read response block
l1_block_valid  out  1  l1_block_data_out holds a valid read response
l1_cache_read  in  1  read request
l1_cache_write  in  1  write request
l1_cache_ready  out  1  high when idle and able to accept a request
l1_cache_hit  out  1  hit/miss result of the last accepted request
mem_data_block  in  BLOCK_SIZE x DATA_WIDTH packed  fill data from memory
mem_ready  in  1  fill data valid (read miss only)
mem_addr  out  ADDR_WIDTH  memory block address
mem_data_out  out  BLOCK_SIZE x DATA_WIDTH packed  write-through data
mem_read  out  1  block fetch request
mem_write  out  1  write-through strobe

Behaviour:
- Storage per set and way: valid bit, tag, data block, LRU rank. All outputs are registered.
- Reset (async, rst_n=0) sets these values:
  - all valid bits 0; LRU ranks set to way number
  - FSM state IDLE, so l1_cache_ready=1
  - l1_block_valid, l1_cache_hit, mem_read and mem_write are 0
  - mem_addr, mem_data_out and l1_block_data_out are 0
- A reset during MISS_WAIT aborts the fetch and returns to IDLE.
- FSM states: IDLE, MISS_WAIT.
- IDLE accepts a request on any rising edge where read or write is high. If both are high, write wins.
- On acceptance, l1_cache_hit is loaded with the lookup result. l1_block_valid and l1_cache_hit then hold until the next accepted request.
- Read hit:
  - l1_block_data_out <= way data; l1_block_valid <= 1; l1_cache_hit <= 1
  - the hit way becomes MRU; stay in IDLE
  - latency: data is visible the cycle after the request is sampled.
- Read miss:
  - l1_cache_hit <= 0; l1_block_valid <= 0
  - mem_addr <= addr; mem_read <= 1; l1_cache_ready <= 0; go to MISS_WAIT.
- MISS_WAIT:
  - hold mem_read and mem_addr; ignore L1 requests.
  - When mem_ready is sampled high, the victim way is filled: the first invalid way in the set, otherwise the LRU way.
  - The fill writes valid=1, the tag and mem_data_block, and the victim way becomes MRU.
  - l1_block_data_out <= mem_data_block; l1_block_valid <= 1; mem_read <= 0; l1_cache_ready <= 1; return to IDLE.
- Write hit:
  - the way data is overwritten with l1_cache_data_in; the way becomes MRU
  - l1_cache_hit <= 1; l1_block_valid <= 0.
- Write miss:
  - the full block is allocated into the victim way (same victim selection as a read miss), with no memory fetch
  - l1_cache_hit <= 0; l1_block_valid <= 0.
- Write-through (hit or miss):
  - mem_addr <= addr; mem_data_out <= l1_cache_data_in; mem_write <= 1 for exactly one cycle.
  - Memory accepts the strobe unconditionally; mem_ready is ignored for writes. The FSM stays in IDLE, so back-to-back writes are accepted every cycle.
- LRU update: the accessed way gets rank 0. Ways whose rank was below the old rank of the accessed way increment; others are unchanged.
- mem_addr and mem_data_out hold their last values when idle.

Test Plan:
- Reset, then read 0x00A -> mem_read=1 with mem_addr=0x00A while waiting. Memory supplies word i = 0xDEADBEEF^i with mem_ready for 1 cycle -> next cycle l1_block_valid=1, l1_cache_ready=1, l1_cache_hit=0, mem_read=0.
- Read 0x00A again -> one cycle later l1_cache_hit=1, l1_block_valid=1, word0=0xDEADBEEF, word31=0xDEADBEEF^31; mem_read stays 0.
- Write 0x014 with word i = 0xA5A5A5A5^i -> next cycle mem_write=1 (one cycle), mem_addr=0x014, mem_data_out equals the block, l1_cache_ready=1, l1_cache_hit=0.
- Write 0x014 with word i = 0x5A5A5A5A^i -> mem_write=1, l1_cache_hit=1. A following read of 0x014 hits and returns word0=0x5A5A5A5A.
- Fill 5 distinct tags in set 10 (addresses 0x00A, 0x08A, 0x10A, 0x18A, 0x20A) -> 0x00A is evicted and a re-read of 0x00A misses. Repeat with 0x00A touched before the 5th fill -> 0x08A is evicted instead.
- Assert rst_n=0 during MISS_WAIT -> mem_read=0, l1_cache_ready=1 immediately. A re-read of 0x00A misses.
